ltc2308_scan_sampler: RTL and testbench

- Upstream front end for the datalogger. Drives the board's LTC2308 8-channel 12-bit SPI ADC.
- Scans channels round-robin at a fixed sample rate and packs each result into one 32-bit status/sample word.
- The word feeds the HPS-visible 32-bit PIO input. Software polls it and detects new samples via a toggle bit.

---
 rtl/ltc2308_scan_sampler.sv | 220 ++++++++++++++++++++++
 tb/tb_ltc2308_scan_sampler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2308_scan_sampler.sv
// ltc2308_scan_sampler
//   Round-robin scan front end for the LTC2308 8-channel 12-bit SPI ADC.
//   Every PERIOD clocks it starts a conversion, shifts the 6-bit config
//   for the current channel out on SDI while reading the 12-bit result
//   back on SDO, and packs the result into a 32-bit status/sample word.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   enable        scan enable (synchronous level)
//   adc_convst    ADC conversion start
//   adc_sck       SPI clock, idles low
//   adc_sdi       config word to the ADC, MSB first
//   adc_sdo       result from the ADC, MSB first
//   data_out      {toggle, overrun, ch[2:0], seq[14:0], code[11:0]}
//   sample_valid  one-cycle pulse when data_out updates
//   busy          high whenever the FSM is not IDLE
module ltc2308_scan_sampler #(
   parameter int CLK_DIV     = 2,
   parameter int CONV_CYCLES = 80,
   parameter int PERIOD      = 5000,
   parameter int NUM_CH      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        adc_convst,
   output logic        adc_sck,
   output logic        adc_sdi,
   input  logic        adc_sdo,
   output logic [31:0] data_out,
   output logic        sample_valid,
   output logic        busy
);

   localparam int PCW = $clog2(PERIOD + 1);
   localparam int CW  = $clog2(CONV_CYCLES + CLK_DIV + 2);

   typedef enum logic [2:0] {
      S_IDLE, S_CONVST, S_CONV, S_SHIFT, S_LATCH
   } state_t;

   state_t          state, state_n;
   logic [PCW-1:0]  pcnt;
   logic            tick;
   logic            enable_d;
   logic            fall;

   logic [CW-1:0]   cnt, cnt_n;
   logic [3:0]      bit_cnt, bit_cnt_n;
   logic [5:0]      cfg, cfg_n;
   logic [11:0]     result, result_n;
   logic [2:0]      ch, ch_n;
   logic [2:0]      prev_ch, prev_ch_n;
   logic            first_flag, first_flag_n;
   logic            dummy_pend, dummy_pend_n;
   logic [14:0]     seq, seq_n;
   logic            overrun, overrun_n;
   logic [31:0]     data_out_n;
   logic            sample_valid_n;
   logic            convst_n, sck_n, sdi_n;

   // Sample-rate timebase. Held at 0 while disabled so the first enabled
   // cycle ticks immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt     <= '0;
         enable_d <= 1'b0;
      end else begin
         enable_d <= enable;
         if (!enable)
            pcnt <= '0;
         else if (pcnt == '0)
            pcnt <= PCW'(PERIOD - 1);
         else
            pcnt <= pcnt - 1'b1;
      end
   end

   assign tick = enable && (pcnt == '0);
   assign fall = enable_d && !enable;
   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         bit_cnt      <= '0;
         cfg          <= '0;
         result       <= '0;
         ch           <= '0;
         prev_ch      <= '0;
         first_flag   <= 1'b1;
         dummy_pend   <= 1'b0;
         seq          <= '0;
         overrun      <= 1'b0;
         data_out     <= '0;
         sample_valid <= 1'b0;
         adc_convst   <= 1'b0;
         adc_sck      <= 1'b0;
         adc_sdi      <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         bit_cnt      <= bit_cnt_n;
         cfg          <= cfg_n;
         result       <= result_n;
         ch           <= ch_n;
         prev_ch      <= prev_ch_n;
         first_flag   <= first_flag_n;
         dummy_pend   <= dummy_pend_n;
         seq          <= seq_n;
         overrun      <= overrun_n;
         data_out     <= data_out_n;
         sample_valid <= sample_valid_n;
         adc_convst   <= convst_n;
         adc_sck      <= sck_n;
         adc_sdi      <= sdi_n;
      end
   end

   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      bit_cnt_n      = bit_cnt;
      cfg_n          = cfg;
      result_n       = result;
      ch_n           = ch;
      prev_ch_n      = prev_ch;
      first_flag_n   = first_flag;
      dummy_pend_n   = dummy_pend;
      seq_n          = seq;
      overrun_n      = overrun;
      data_out_n     = data_out;
      sample_valid_n = 1'b0;
      convst_n       = adc_convst;
      sck_n          = adc_sck;
      sdi_n          = adc_sdi;

      // tick and fall can never coincide (tick needs enable high)
      if (fall)
         overrun_n = 1'b0;
      else if (tick && state != S_IDLE)
         overrun_n = 1'b1;

      // A disable mid-frame must not kill that frame's publish, so the
      // dummy request is parked until LATCH has used the current flag.
      if (fall) begin
         if (state == S_IDLE) first_flag_n = 1'b1;
         else                 dummy_pend_n = 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (tick) begin
               state_n  = S_CONVST;
               cnt_n    = '0;
               convst_n = 1'b1;
               // single-ended, unipolar, awake; channel bits are O/S,S1,S0
               cfg_n    = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
            end
         end
         S_CONVST: begin
            if (cnt == CW'(1)) begin
               state_n  = S_CONV;
               cnt_n    = '0;
               convst_n = 1'b0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_CONV: begin
            if (cnt == CW'(CONV_CYCLES - 1)) begin
               state_n   = S_SHIFT;
               cnt_n     = '0;
               bit_cnt_n = '0;
               sdi_n     = cfg[5];
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt == CW'(CLK_DIV - 1)) begin
               cnt_n = '0;
               if (!adc_sck) begin
                  sck_n    = 1'b1;
                  result_n = {result[10:0], adc_sdo};
               end else begin
                  // cfg is consumed as a zero-filling shifter, so SDI
                  // drops to 0 once all six bits have gone out
                  sck_n = 1'b0;
                  sdi_n = cfg[4];
                  cfg_n = {cfg[4:0], 1'b0};
                  if (bit_cnt == 4'd11)
                     state_n = S_LATCH;
                  else
                     bit_cnt_n = bit_cnt + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_LATCH: begin
            state_n = S_IDLE;
            // the ADC pipelines its config: this result is prev_ch's
            if (!first_flag) begin
               data_out_n     = {~data_out[31], overrun, prev_ch, seq, result};
               sample_valid_n = 1'b1;
               seq_n          = seq + 1'b1;
            end
            first_flag_n = dummy_pend || fall;
            dummy_pend_n = 1'b0;
            prev_ch_n    = ch;
            ch_n         = (ch == 3'(NUM_CH - 1)) ? 3'd0 : ch + 3'd1;
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ltc2308_scan_sampler.sv
// tb_ltc2308_scan_sampler
//   Two instances share clock and reset: u_dut (PERIOD=200) with a
//   behavioural LTC2308 model, and u_ovr (PERIOD=100, SDO tied high)
//   whose frames are longer than the sample period.
module tb_ltc2308_scan_sampler;

   localparam int MAIN_PERIOD = 200;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        enable_o = 1'b0;

   logic        adc_convst, adc_sck, adc_sdi, sample_valid, busy;
   logic        adc_sdo = 1'b0;
   logic [31:0] data_out;

   logic        convst_o, sck_o, sdi_o, valid_o, busy_o;
   logic [31:0] dout_o;

   always #10 clk = ~clk;

   ltc2308_scan_sampler #(.PERIOD(MAIN_PERIOD)) u_dut (
      .clk(clk), .reset(reset), .enable(enable),
      .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi),
      .adc_sdo(adc_sdo), .data_out(data_out),
      .sample_valid(sample_valid), .busy(busy)
   );

   ltc2308_scan_sampler #(.PERIOD(100)) u_ovr (
      .clk(clk), .reset(reset), .enable(enable_o),
      .adc_convst(convst_o), .adc_sck(sck_o), .adc_sdi(sdi_o),
      .adc_sdo(1'b1), .data_out(dout_o),
      .sample_valid(valid_o), .busy(busy_o)
   );

   // ---------------- ADC model + output monitor (u_dut) ----------------
   int          cyc = 0, n_frames = 0, n_pub = 0, rise_cyc = 0, cap_n = 0;
   logic        cq = 1'b0, sq = 1'b0;
   logic        mode = 1'b0;           // 0: code 0xA5C, 1: 0x100 + channel
   logic [11:0] sdo_sr = '0;
   logic [5:0]  cap = '0, conv_cfg;
   logic [2:0]  ch_m;
   logic [5:0]  cfg_log [64];
   logic [31:0] got_q [$];
   int          lat_q [$];

   always @(negedge clk) begin
      cyc++;
      if (adc_convst && !cq) begin
         // converts the channel configured during the previous frame
         conv_cfg = cap;
         ch_m     = {conv_cfg[3], conv_cfg[2], conv_cfg[4]};
         sdo_sr   = mode ? (12'h100 + {9'd0, ch_m}) : 12'hA5C;
         adc_sdo  = sdo_sr[11];
         cap      = '0;
         cap_n    = 0;
         rise_cyc = cyc;
         n_frames++;
      end
      if (adc_sck && !sq && cap_n < 6) begin
         cap = {cap[4:0], adc_sdi};
         cap_n++;
         if (cap_n == 6 && n_frames >= 1 && n_frames <= 64)
            cfg_log[n_frames-1] = cap;
      end
      if (!adc_sck && sq) begin
         sdo_sr  = {sdo_sr[10:0], 1'b0};
         adc_sdo = sdo_sr[11];
      end
      if (sample_valid) begin
         got_q.push_back(data_out);
         lat_q.push_back(cyc - rise_cyc);
         n_pub++;
      end
      cq = adc_convst;
      sq = adc_sck;
   end

   // ---------------- checking ----------------
   int          n_cmp = 0, n_mis = 0, rd = 0;
   logic        exp_tog = 1'b0;
   logic [14:0] exp_seq = '0;
   logic [31:0] sb [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic ovr, input logic [2:0] ch, input logic [11:0] code);
      exp_tog = ~exp_tog;
      sb.push_back({exp_tog, ovr, ch, exp_seq, code});
      exp_seq = exp_seq + 15'd1;
   endtask

   task automatic drain(input string tag);
      logic [31:0] e;
      int w;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         w = 0;
         while (got_q.size() <= rd && w < 400) begin
            @(negedge clk);
            w++;
         end
         if (got_q.size() <= rd) begin
            chk($sformatf("%s publish timeout", tag), 32'(got_q.size()), 32'(rd + 1));
         end else begin
            chk($sformatf("%s word", tag), got_q[rd], e);
            chk($sformatf("%s latency", tag), 32'(lat_q[rd]), 32'd131);
            rd++;
         end
      end
   endtask

   task automatic wait_frames(input int n, input string tag);
      int tgt, w;
      tgt = n_frames + n;
      w = 0;
      while (n_frames < tgt && w < n * 300) begin
         @(negedge clk);
         w++;
      end
      chk($sformatf("%s frame count", tag), 32'(n_frames), 32'(tgt));
   endtask

   task automatic wait_pub_o(output int k, output logic [31:0] w);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!valid_o && k < 600);
      if (!valid_o) chk("ovr publish timeout", 32'(valid_o), 32'd1);
      w = dout_o;
   endtask

   initial begin
      int          np, f0, k, w;
      logic [31:0] word;

      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst data_out", data_out, 32'h0);
      chk("rst sample_valid", 32'(sample_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst adc_convst", 32'(adc_convst), 32'd0);
      chk("rst adc_sck", 32'(adc_sck), 32'd0);
      chk("rst adc_sdi", 32'(adc_sdi), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // first frame is a dummy, second publishes channel 0
      push_exp(1'b0, 3'd0, 12'hA5C);          // 0x80000A5C
      enable = 1'b1;
      wait_frames(2, "startup");
      chk("startup dummy suppressed", 32'(n_pub), 32'd0);
      drain("first sample");

      // round-robin with channel-tagged codes, wrapping 7 -> 0
      mode = 1'b1;
      for (int f = 2; f < 22; f++)
         push_exp(1'b0, 3'((f - 1) % 8), 12'h100 + 12'((f - 1) % 8));
      drain("round robin");
      chk("cfg word ch5", 32'(cfg_log[5]), 32'(6'b111010));
      chk("cfg word ch7", 32'(cfg_log[7]), 32'(6'b111110));
      chk("cfg word ch0 after wrap", 32'(cfg_log[8]), 32'(6'b100010));

      // reset in the middle of a shift
      w = 0;
      while (!adc_sck && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk("reach SHIFT", 32'(adc_sck), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst adc_sck", 32'(adc_sck), 32'd0);
      chk("midrst adc_convst", 32'(adc_convst), 32'd0);
      chk("midrst adc_sdi", 32'(adc_sdi), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst data_out", data_out, 32'h0);
      reset = 1'b0;
      exp_tog = 1'b0;
      exp_seq = '0;
      push_exp(1'b0, 3'd0, 12'h100);          // 0x80000100
      np = n_pub;
      wait_frames(2, "post reset");
      chk("post reset dummy suppressed", 32'(n_pub), 32'(np));
      drain("post reset sample");

      // drop enable during CONV: the frame still publishes
      push_exp(1'b0, 3'd1, 12'h101);          // 0x08001101
      wait_frames(1, "pre disable");
      repeat (10) @(negedge clk);
      enable = 1'b0;
      drain("disable mid-conv");
      f0 = n_frames;
      repeat (2 * MAIN_PERIOD + 20) @(negedge clk);
      chk("no convst while disabled", 32'(n_frames), 32'(f0));
      chk("idle while disabled", 32'(busy), 32'd0);

      // re-enable: immediate CONVST, dummy, then channel 3 with seq 2
      push_exp(1'b0, 3'd3, 12'h103);          // 0x98002103
      np = n_pub;
      enable = 1'b1;
      @(negedge clk);
      chk("convst on first enabled cycle", 32'(adc_convst), 32'd1);
      @(negedge clk);
      wait_frames(1, "re-enable");
      chk("re-enable dummy suppressed", 32'(n_pub), 32'(np));
      drain("re-enable sample");
      enable = 1'b0;

      // overrun: PERIOD=100 is shorter than a 131-cycle frame
      enable_o = 1'b1;
      wait_pub_o(k, word);
      chk("ovr first publish cycle", 32'(k), 32'd332);
      chk("ovr word1", word, 32'hC000_0FFF);
      wait_pub_o(k, word);
      chk("ovr word2 sticky", word, 32'h4800_1FFF);
      w = 0;
      while (!convst_o && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("ovr reach convst", 32'(convst_o), 32'd1);
      repeat (10) @(negedge clk);
      enable_o = 1'b0;
      wait_pub_o(k, word);
      chk("ovr cleared by disable", word, 32'h9000_2FFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
